alu_issue: RTL

Operand-fetch, issue and writeback stage wrapped around the combinational ALU. Holds the 32×32 architectural register file and accepts one decoded command per cycle on a valid/ready handshake. It reads rs1 and rs2, or rs1 and an immediate, into registered ALU operand outputs, then captures the ALU result and writes it back to rd when the downstream consumer accepts it. Single-cycle bypass lets back-to-back dependent commands run at full throughput.

---
 rtl/alu_issue.sv | 90 +++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Operand-fetch, issue and writeback stage around a combinational ALU.
// Holds the 32x32 register file; one command in flight, with a bypass from the retiring result.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;
  localparam logic [3:0]  ALU_NONE = 4'd0;

  logic [DW-1:0] regs [NREG];
  logic          accept;
  logic          retire;
  logic          wb_en;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;
  assign wb_en    = retire && (out_rd != '0);
  assign out_data = alu_res;
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  // Source operand read with bypass from the result retiring this cycle
  always_comb begin
    src_a = '0;
    src_b = in_imm;
    if (in_rs1 != '0) begin
      src_a = (wb_en && (out_rd == in_rs1)) ? alu_res : regs[in_rs1];
    end
    if (!in_use_imm) begin
      src_b = '0;
      if (in_rs2 != '0) begin
        src_b = (wb_en && (out_rd == in_rs2)) ? alu_res : regs[in_rs2];
      end
    end
  end

  // One-entry issue register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= ALU_NONE;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_a     <= src_a;
      alu_b     <= src_b;
      alu_op    <= in_op;
      out_rd    <= in_rd;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

  // Register file; entry 0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[AW'(i)] <= '0;
      end
    end else if (wb_en) begin
      regs[out_rd] <= alu_res;
    end
  end

endmodule
